// File: rtl/rx_queue_sf.sv
// ============================================================================
// rx_queue_sf : store-and-forward MAC RX byte stream to 8-bit AXI4-Stream.
// Frames are buffered in a packet RAM; only good frames are exposed on AXI.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rx_queue_sf #(
  parameter int AXI_DATA_WIDTH = 8,
  parameter int ADDR_WIDTH     = 11
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_data_valid,
  input  logic                        rx_good_frame,
  input  logic                        rx_bad_frame,
  output logic [AXI_DATA_WIDTH-1:0]   tdata,
  output logic [AXI_DATA_WIDTH/8-1:0] tstrb,
  output logic                        tvalid,
  output logic                        tlast,
  input  logic                        tready,
  output logic                        rx_pkt_good,
  output logic                        rx_pkt_bad,
  output logic                        rx_pkt_dropped
);

  localparam int                PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]     DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_FRAME = 2'd1,
    W_DROP  = 2'd2
  } wstate_t;

  logic [8:0]      mem [DEPTH];

  wstate_t         state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic            good_q, good_d, bad_q, bad_d, drop_q, drop_d;
  logic            tvalid_q, tvalid_d;
  logic [8:0]      dout_q;

  logic [PW-1:0]   ptr1, ptr2, free;
  logic            has1, has2, end_any, rd_en;
  logic            we0, we1;
  logic [ADDR_WIDTH-1:0] wa0, wa1;
  logic [8:0]      wd0, wd1;

  assign ptr1    = wr_ptr_q + PW'(1);
  assign ptr2    = wr_ptr_q + PW'(2);
  assign free    = DEPTH - (wr_ptr_q - rd_ptr_q);
  assign has1    = (free != '0);
  assign has2    = |free[PW-1:1];
  assign end_any = rx_good_frame | rx_bad_frame;

  // A byte arriving with the end flag is the last byte: two writes this cycle.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    good_d       = 1'b0;
    bad_d        = 1'b0;
    drop_d       = 1'b0;
    we0          = 1'b0;
    we1          = 1'b0;
    wa0          = wr_ptr_q[ADDR_WIDTH-1:0];
    wa1          = ptr1[ADDR_WIDTH-1:0];
    wd0          = {1'b0, pend_q};
    wd1          = {1'b1, rx_data};
    case (state_q)
      W_IDLE: begin
        if (end_any) begin
          if (rx_data_valid && !rx_bad_frame) begin
            if (has1) begin
              we0          = 1'b1;
              wd0          = {1'b1, rx_data};
              wr_ptr_d     = ptr1;
              commit_ptr_d = ptr1;
              good_d       = 1'b1;
            end else begin
              drop_d = 1'b1;
            end
          end else begin
            bad_d = 1'b1;
          end
        end else if (rx_data_valid) begin
          pend_d     = rx_data;
          pend_vld_d = 1'b1;
          state_d    = W_FRAME;
        end
      end
      W_FRAME: begin
        if (rx_bad_frame) begin
          wr_ptr_d   = commit_ptr_q;
          pend_vld_d = 1'b0;
          bad_d      = 1'b1;
          state_d    = W_IDLE;
        end else if (rx_good_frame && pend_vld_q) begin
          pend_vld_d = 1'b0;
          state_d    = W_IDLE;
          if (rx_data_valid ? has2 : has1) begin
            we0          = 1'b1;
            we1          = rx_data_valid;
            wd0          = {~rx_data_valid, pend_q};
            wr_ptr_d     = rx_data_valid ? ptr2 : ptr1;
            commit_ptr_d = rx_data_valid ? ptr2 : ptr1;
            good_d       = 1'b1;
          end else begin
            wr_ptr_d = commit_ptr_q;
            drop_d   = 1'b1;
          end
        end else if (rx_data_valid) begin
          if (has1) begin
            we0      = 1'b1;
            wr_ptr_d = ptr1;
            pend_d   = rx_data;
          end else begin
            pend_vld_d = 1'b0;
            state_d    = W_DROP;
          end
        end
      end
      W_DROP: begin
        if (end_any) begin
          wr_ptr_d   = commit_ptr_q;
          pend_vld_d = 1'b0;
          drop_d     = 1'b1;
          state_d    = W_IDLE;
        end
      end
      default: state_d = W_IDLE;
    endcase
  end

  // Output register doubles as the RAM read register; it holds while stalled.
  assign rd_en = (rd_ptr_q != commit_ptr_q) && (!tvalid_q || tready);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    tvalid_d = tvalid_q;
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      tvalid_d = 1'b1;
    end else if (tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= W_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      good_q       <= 1'b0;
      bad_q        <= 1'b0;
      drop_q       <= 1'b0;
      tvalid_q     <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      drop_q       <= drop_d;
      tvalid_q     <= tvalid_d;
      if (rd_en) dout_q <= mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    end
  end

  assign tdata          = dout_q[7:0];
  assign tlast          = dout_q[8];
  assign tvalid         = tvalid_q;
  assign tstrb          = '1;
  assign rx_pkt_good    = good_q;
  assign rx_pkt_bad     = bad_q;
  assign rx_pkt_dropped = drop_q;

endmodule

`default_nettype wire
